// File: rtl/cpu_bp_pkg.sv
// Shared branch-prediction package.
// Holds the default address width and queue depth used by both the
// fetch-side predictor and the execute-side resolver, the instruction
// size used for fall-through PCs, and the in-flight branch record type.
package cpu_bp_pkg;

    localparam int BP_XLEN        = 32;
    localparam int BP_DEPTH_WIDTH = 2;
    localparam int INSN_BYTES     = 4;

    // One in-flight conditional branch: its PC and the direction fetch
    // predicted for it.
    typedef struct packed {
        logic [BP_XLEN-1:0] pc;
        logic               pred_taken;
    } bp_entry_t;

endpackage

// File: rtl/cpu_branch_queue.sv
// In-order queue of in-flight branch predictions.
// Circular buffer with read/write pointers that wrap modulo the depth and
// an explicit occupancy count one bit wider than the pointers.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   push         write push_entry at the tail (ignored when full unless popping)
//   push_entry   branch record to append
//   pop          drop the head entry (caller only pops a non-empty queue)
//   clear        empty the queue after any pop; a simultaneous push is dropped
//   head         oldest entry
//   count        number of valid entries
//   full         count equals the depth
module cpu_branch_queue
    import cpu_bp_pkg::*;
#(
    parameter int DEPTH_WIDTH = BP_DEPTH_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  bp_entry_t            push_entry,
    input  logic                 pop,
    input  logic                 clear,
    output bp_entry_t            head,
    output logic [DEPTH_WIDTH:0] count,
    output logic                 full
);

    localparam int DEPTH = 1 << DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0] DEPTH_CNT = (DEPTH_WIDTH + 1)'(DEPTH);

    bp_entry_t              mem [DEPTH];
    logic [DEPTH_WIDTH-1:0] rd_ptr;
    logic [DEPTH_WIDTH-1:0] wr_ptr;
    logic                   do_push;

    assign full    = (count == DEPTH_CNT);
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push && (!full || pop) && !clear;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            // Write pointer stays put; the read pointer catches up to it.
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{DEPTH_WIDTH{1'b0}}, do_push} - {{DEPTH_WIDTH{1'b0}}, pop};
        end
    end

endmodule

// File: rtl/cpu_branch_resolver.sv
// Execute-stage branch resolver.
// Keeps the fetch-time prediction of each in-flight conditional branch,
// compares it with the actual outcome when execute resolves the oldest
// branch, trains the predictor through update/update_addr/update_taken,
// and on a wrong prediction redirects fetch and squashes younger entries.
//
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   push, push_pc, push_taken          branch issued by fetch with its prediction
//   full                               queue full, fetch must stall branches
//   resolve, resolve_pc,
//   resolve_taken, resolve_target      outcome of the oldest branch
//   flush                              external squash of all in-flight branches
//   update, update_addr, update_taken  predictor training pulse
//   mispredict, redirect_pc            fetch redirect pulse and target
//   err                                sticky protocol error (bad resolve)
//   branch_cnt, mispredict_cnt         wrapping performance counters
// Entry width follows the package BP_XLEN; XLEN is expected to match it.
module cpu_branch_resolver
    import cpu_bp_pkg::*;
#(
    parameter int XLEN        = BP_XLEN,
    parameter int DEPTH_WIDTH = BP_DEPTH_WIDTH,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [XLEN-1:0]      push_pc,
    input  logic                 push_taken,
    output logic                 full,
    input  logic                 resolve,
    input  logic [XLEN-1:0]      resolve_pc,
    input  logic                 resolve_taken,
    input  logic [XLEN-1:0]      resolve_target,
    input  logic                 flush,
    output logic                 update,
    output logic [XLEN-1:0]      update_addr,
    output logic                 update_taken,
    output logic                 mispredict,
    output logic [XLEN-1:0]      redirect_pc,
    output logic                 err,
    output logic [CNT_WIDTH-1:0] branch_cnt,
    output logic [CNT_WIDTH-1:0] mispredict_cnt
);

    bp_entry_t            push_entry;
    bp_entry_t            head;
    logic [DEPTH_WIDTH:0] count;
    logic                 resolve_ok;
    logic                 wrong_dir;
    logic                 squash;
    logic [XLEN-1:0]      fall_through;

    assign push_entry = '{pc: push_pc, pred_taken: push_taken};

    assign resolve_ok   = resolve && (count != '0) && (resolve_pc == head.pc);
    assign wrong_dir    = resolve_ok && (resolve_taken != head.pred_taken);
    // Everything behind a mispredicted branch is on the wrong path.
    assign squash       = flush || wrong_dir;
    assign fall_through = head.pc + XLEN'(INSN_BYTES);

    // Only a valid resolve pops, so a push into a full queue is taken only
    // when a slot really frees up; a bad resolve cannot cause an overwrite.
    cpu_branch_queue #(
        .DEPTH_WIDTH (DEPTH_WIDTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (resolve_ok),
        .clear      (squash),
        .head       (head),
        .count      (count),
        .full       (full)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            update         <= 1'b0;
            update_addr    <= '0;
            update_taken   <= 1'b0;
            mispredict     <= 1'b0;
            redirect_pc    <= '0;
            err            <= 1'b0;
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            update     <= resolve_ok;
            mispredict <= wrong_dir;
            if (resolve_ok) begin
                update_addr  <= head.pc;
                update_taken <= resolve_taken;
                branch_cnt   <= branch_cnt + CNT_WIDTH'(1);
            end
            if (wrong_dir) begin
                mispredict_cnt <= mispredict_cnt + CNT_WIDTH'(1);
                redirect_pc    <= resolve_taken ? resolve_target : fall_through;
            end
            if (resolve && !resolve_ok) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_branch_resolver.sv
module tb_cpu_branch_resolver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        push;
    logic [31:0] push_pc;
    logic        push_taken;
    logic        full;
    logic        resolve;
    logic [31:0] resolve_pc;
    logic        resolve_taken;
    logic [31:0] resolve_target;
    logic        flush;
    logic        update;
    logic [31:0] update_addr;
    logic        update_taken;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        err;
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    always #5 clk = ~clk;

    cpu_branch_resolver dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .push           (push),
        .push_pc        (push_pc),
        .push_taken     (push_taken),
        .full           (full),
        .resolve        (resolve),
        .resolve_pc     (resolve_pc),
        .resolve_taken  (resolve_taken),
        .resolve_target (resolve_target),
        .flush          (flush),
        .update         (update),
        .update_addr    (update_addr),
        .update_taken   (update_taken),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc),
        .err            (err),
        .branch_cnt     (branch_cnt),
        .mispredict_cnt (mispredict_cnt)
    );

    // Reference model: in-flight branches in program order.
    typedef struct {
        logic [31:0] pc;
        bit          pred;
    } ent_t;

    ent_t        q[$];
    bit          m_err;
    int unsigned m_bcnt;
    int unsigned m_mcnt;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        push           = 1'b0;
        push_pc        = '0;
        push_taken     = 1'b0;
        resolve        = 1'b0;
        resolve_pc     = '0;
        resolve_taken  = 1'b0;
        resolve_target = '0;
        flush          = 1'b0;
    endtask

    // Applies rst_n=0 for one edge with whatever inputs the caller left driven.
    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        q.delete();
        m_err  = 0;
        m_bcnt = 0;
        m_mcnt = 0;
        chk("rst_full", full, 0);
        chk("rst_update", update, 0);
        chk("rst_update_addr", update_addr, 0);
        chk("rst_update_taken", update_taken, 0);
        chk("rst_mispredict", mispredict, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_err", err, 0);
        chk("rst_branch_cnt", branch_cnt, 0);
        chk("rst_mispredict_cnt", mispredict_cnt, 0);
    endtask

    // One clock: drive inputs, predict from the model, check after the edge.
    task automatic cyc(input bit p, input logic [31:0] ppc, input bit ptk,
                       input bit r, input logic [31:0] rpc, input bit rtk,
                       input logic [31:0] rtgt, input bit f);
        bit          valid;
        bit          mis;
        bit          acc;
        logic [31:0] eaddr;
        logic [31:0] eredir;
        push           = p;
        push_pc        = ppc;
        push_taken     = ptk;
        resolve        = r;
        resolve_pc     = rpc;
        resolve_taken  = rtk;
        resolve_target = rtgt;
        flush          = f;
        chk("full", full, (q.size() == 4) ? 1 : 0);
        valid  = 0;
        mis    = 0;
        eaddr  = '0;
        eredir = '0;
        if (r && q.size() != 0) begin
            if (rpc == q[0].pc) begin
                valid  = 1;
                mis    = (rtk != q[0].pred);
                eaddr  = q[0].pc;
                eredir = rtk ? rtgt : q[0].pc + 32'd4;
            end
        end
        if (r && !valid) m_err = 1;
        if (valid) m_bcnt++;
        if (mis) m_mcnt++;
        acc = p && (q.size() < 4 || r);
        if (valid) void'(q.pop_front());
        if (f || mis) q.delete();
        else if (acc) q.push_back('{pc: ppc, pred: ptk});
        @(posedge clk);
        #1;
        chk("update", update, valid);
        chk("mispredict", mispredict, mis);
        if (valid) begin
            chk("update_addr", update_addr, eaddr);
            chk("update_taken", update_taken, rtk);
        end
        if (mis) chk("redirect_pc", redirect_pc, eredir);
        chk("err", err, m_err);
        chk("branch_cnt", branch_cnt, m_bcnt);
        chk("mispredict_cnt", mispredict_cnt, m_mcnt);
        idle();
    endtask

    task automatic p_only(input logic [31:0] pc, input bit tk);
        cyc(1, pc, tk, 0, 0, 0, 0, 0);
    endtask

    task automatic r_only(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
        cyc(0, 0, 0, 1, pc, tk, tgt, 0);
    endtask

    initial begin
        idle();
        do_reset();

        // Correct prediction.
        p_only(32'h100, 1);
        r_only(32'h100, 1, 32'h180);

        // Predicted taken, actually not taken: fall-through redirect.
        p_only(32'h200, 1);
        r_only(32'h200, 0, 32'h280);

        // Mispredict squashes younger entries.
        p_only(32'h300, 0);
        p_only(32'h310, 1);
        p_only(32'h320, 1);
        r_only(32'h300, 1, 32'h400);
        r_only(32'h310, 1, 32'h500);
        do_reset();

        // Fill, drop on full, push+pop on full, pointer wrap.
        p_only(32'hA00, 1);
        p_only(32'hA10, 0);
        p_only(32'hA20, 1);
        p_only(32'hA30, 0);
        p_only(32'hA40, 1);
        cyc(1, 32'hA50, 1, 1, 32'hA00, 1, 32'hF00, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        r_only(32'hA10, 0, 0);
        r_only(32'hA20, 1, 32'hF20);
        r_only(32'hA30, 0, 0);
        r_only(32'hA50, 1, 32'hF50);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // Bad resolves: empty queue, then PC mismatch.
        r_only(32'hB00, 1, 0);
        do_reset();
        p_only(32'hB10, 1);
        r_only(32'hB14, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();

        // Flush alongside a valid resolve and a push.
        p_only(32'h600, 0);
        p_only(32'h610, 0);
        p_only(32'h620, 0);
        cyc(1, 32'h700, 1, 1, 32'h600, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        r_only(32'h610, 0, 0);
        do_reset();

        // Reset on the same edge as a mispredicting resolve.
        p_only(32'h800, 1);
        resolve       = 1'b1;
        resolve_pc    = 32'h800;
        resolve_taken = 1'b0;
        do_reset();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            bit          p;
            bit          r;
            bit          f;
            bit          tk;
            bit          ok;
            logic [31:0] rpc;
            p   = ($urandom_range(0, 1) == 1);
            r   = ($urandom_range(0, 2) != 0);
            f   = ($urandom_range(0, 19) == 0);
            tk  = ($urandom_range(0, 1) == 1);
            rpc = $urandom() & 32'hFFFF_FFFC;
            if (q.size() != 0 && $urandom_range(0, 7) != 0) rpc = q[0].pc;
            ok = (q.size() != 0) && (rpc == q[0].pc);
            if (q.size() == 4 && r && !ok) p = 0;
            cyc(p, $urandom() & 32'hFFFF_FFFC, ($urandom_range(0, 1) == 1),
                r, rpc, tk, $urandom() & 32'hFFFF_FFFC, f);
            if ($urandom_range(0, 99) == 0) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
